as_master_bpi: RTL and testbench

//  Wishbone initiator BPI: the core-side counterpart to the slave BPI. Accepts single

---
 rtl/as_master_bpi.sv | 142 ++++++++++++++
 tb/tb_as_master_bpi.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/as_master_bpi.sv
// Wishbone classic initiator: one outstanding single read/write per client request.
// Optional bus watchdog enabled by defining AS_MBPI_TIMEOUT_EN.
module as_master_bpi #(
  parameter int addr_width     = 64,
  parameter int data_width     = 64,
  parameter int sel_width      = data_width / 8,
  parameter int timeout_cycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [addr_width-1:0] req_addr_i,
  input  logic [data_width-1:0] req_dat_i,
  input  logic [sel_width-1:0]  req_sel_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [data_width-1:0] rdat_o,
  output logic                  err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [addr_width-1:0] addr_o,
  output logic [data_width-1:0] dat_o,
  output logic [sel_width-1:0]  sel_o,
  input  logic [data_width-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] dat_q, dat_d, rdat_q, rdat_d;
  logic [sel_width-1:0]  sel_q, sel_d;
  logic                  tmo_hit;

`ifdef AS_MBPI_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Fires in the BUS cycle whose count would reach the limit.
  assign tmo_hit = (({1'b0, tmo_cnt_q} + (TW+1)'(1)) == (TW+1)'(timeout_cycles));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != S_BUS)
      tmo_cnt_d = '0;
    else if (!(ack_i || err_i))
      tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    rdat_d   = rdat_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        if (stb_q && (ack_i || err_i || tmo_hit)) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          rvalid_d = 1'b1;
          // Error beats ack; an ack beats a coincident timeout.
          err_d    = err_i || (!ack_i && tmo_hit);
          if (ack_i && !err_i && !we_q)
            rdat_d = dat_i;
          state_d  = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      rdat_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      rdat_q   <= rdat_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign ready_o  = (state_q != S_BUS);
  assign rvalid_o = rvalid_q;
  assign rdat_o   = rdat_q;
  assign err_o    = err_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = stb_q;
  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign dat_o    = dat_q;
  assign sel_o    = sel_q;

endmodule

// File: tb/tb_as_master_bpi.sv
// Directed bench for as_master_bpi: writes, wait-state reads, error priority,
// back-to-back streaming, async reset abort and the bus watchdog.
module tb_as_master_bpi;
  localparam int AW = 64, DW = 64, SW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_dat = '0;
  logic [SW-1:0] req_sel = '0;
  logic          ready, rvalid, err, cyc, stb, we;
  logic [DW-1:0] rdat, dat_o, dat_i, dat_drv = '0;
  logic [AW-1:0] addr;
  logic [SW-1:0] sel;
  logic          ack_i, err_i, ack_drv = 1'b0, err_drv = 1'b0, auto = 1'b0;

  int nvec = 0, nerr = 0;

  // Zero-wait slave model: acks every strobe and returns ~address.
  assign ack_i = auto ? stb : ack_drv;
  assign err_i = err_drv;
  assign dat_i = auto ? ~addr : dat_drv;

  always #5 clk = ~clk;

  as_master_bpi #(.addr_width(AW), .data_width(DW), .sel_width(SW), .timeout_cycles(4)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_dat_i(req_dat), .req_sel_i(req_sel), .ready_o(ready), .rvalid_o(rvalid),
    .rdat_o(rdat), .err_o(err), .cyc_o(cyc), .stb_o(stb), .we_o(we), .addr_o(addr),
    .dat_o(dat_o), .sel_o(sel), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    req = 1'b1; req_we = w; req_addr = a; req_dat = d; req_sel = s;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cyc", 64'(cyc), 0);  chk("rst_stb", 64'(stb), 0);
    chk("rst_rvalid", 64'(rvalid), 0); chk("rst_err", 64'(err), 0);
    chk("rst_addr", addr, 0); chk("rst_rdat", rdat, 0); chk("rst_ready", 64'(ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // 1: zero-wait write
    set_req(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    step();
    chk("t1_stb", 64'(stb), 1); chk("t1_cyc", 64'(cyc), 1); chk("t1_we", 64'(we), 1);
    chk("t1_addr", addr, 64'h1000); chk("t1_dat", dat_o, 64'hDEADBEEF_CAFEF00D);
    chk("t1_sel", 64'(sel), 64'hFF); chk("t1_ready", 64'(ready), 0);
    req = 1'b0; ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    chk("t1_rvalid", 64'(rvalid), 1); chk("t1_err", 64'(err), 0); chk("t1_stb_off", 64'(stb), 0);
    step();
    chk("t1_rvalid_pulse", 64'(rvalid), 0);

    // 2: read with three wait states
    set_req(1'b0, 64'h2000, 64'h0, 8'h0F);
    step();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_stb", 64'(stb), 1); chk("t2_addr", addr, 64'h2000); chk("t2_sel", 64'(sel), 64'h0F);
      chk("t2_rvalid_early", 64'(rvalid), 0);
      if (i == 3) begin ack_drv = 1'b1; dat_drv = 64'h0123456789ABCDEF; end
      step();
    end
    ack_drv = 1'b0; dat_drv = '0;
    chk("t2_rvalid", 64'(rvalid), 1); chk("t2_rdat", rdat, 64'h0123456789ABCDEF);
    chk("t2_err", 64'(err), 0);
    step();

    // 3: ack and err together -> error, rdat untouched
    set_req(1'b0, 64'h3000, 64'h0, 8'hFF);
    step();
    req = 1'b0; ack_drv = 1'b1; err_drv = 1'b1; dat_drv = 64'h5555_AAAA_5555_AAAA;
    step();
    ack_drv = 1'b0; err_drv = 1'b0;
    chk("t3_rvalid", 64'(rvalid), 1); chk("t3_err", 64'(err), 1);
    chk("t3_rdat", rdat, 64'h0123456789ABCDEF);
    step();
    chk("t3_err_clr", 64'(err), 0); chk("t3_rvalid_clr", 64'(rvalid), 0);

    // 4: back-to-back reads with req held high
    auto = 1'b1;
    set_req(1'b0, 64'h4000, 64'h0, 8'hFF);
    step();
    chk("t4_stb0", 64'(stb), 1); chk("t4_addr0", addr, 64'h4000);
    req_addr = 64'h4008;
    step();
    chk("t4_stb1", 64'(stb), 0); chk("t4_rv0", 64'(rvalid), 1);
    chk("t4_rdat0", rdat, ~64'h4000); chk("t4_ready_resp", 64'(ready), 1);
    step();
    chk("t4_stb2", 64'(stb), 1); chk("t4_addr1", addr, 64'h4008);
    req_addr = 64'h4010;
    step();
    chk("t4_stb3", 64'(stb), 0); chk("t4_rv1", 64'(rvalid), 1); chk("t4_rdat1", rdat, ~64'h4008);
    step();
    chk("t4_stb4", 64'(stb), 1); chk("t4_addr2", addr, 64'h4010);
    req = 1'b0;
    step();
    chk("t4_rv2", 64'(rvalid), 1); chk("t4_rdat2", rdat, ~64'h4010);
    step();
    chk("t4_idle_rv", 64'(rvalid), 0);

    // 5: async reset while strobing
    auto = 1'b0;
    set_req(1'b1, 64'h5000, 64'h77, 8'h01);
    step();
    req = 1'b0;
    chk("t5_stb_pre", 64'(stb), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cyc_rst", 64'(cyc), 0); chk("t5_stb_rst", 64'(stb), 0); chk("t5_addr_rst", addr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_no_rvalid", 64'(rvalid), 0);
      step();
    end
    auto = 1'b1;
    set_req(1'b1, 64'h5008, 64'h99, 8'h03);
    step();
    req = 1'b0;
    chk("t5_stb_new", 64'(stb), 1); chk("t5_addr_new", addr, 64'h5008);
    step();
    chk("t5_rv_new", 64'(rvalid), 1); chk("t5_err_new", 64'(err), 0);
    step();
    auto = 1'b0;

    // 6: silent slave
    set_req(1'b0, 64'h6000, 64'h0, 8'hFF);
    step();
    req = 1'b0;
`ifdef AS_MBPI_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("t6_stb", 64'(stb), 1); chk("t6_rv_early", 64'(rvalid), 0);
      step();
    end
    chk("t6_rvalid", 64'(rvalid), 1); chk("t6_err", 64'(err), 1); chk("t6_stb_off", 64'(stb), 0);
`else
    begin
      int hi = 0;
      for (int i = 0; i < 110; i++) begin
        if (stb === 1'b1 && rvalid === 1'b0) hi++;
        step();
      end
      chk("t6_stb_held", 64'(hi), 110);
    end
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    chk("t6_rvalid", 64'(rvalid), 1); chk("t6_err", 64'(err), 0);
`endif
    step();
    chk("t6_done", 64'(rvalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
